// File: rtl/l2_line_responder.sv
// Word-serial next-level memory for the L1 dcache: one LOAD/STORE word per request, fixed latency.
// Optional L2_ADDR_CHECK_EN adds l1_req_error for misaligned or out-of-range addresses.
module l2_line_responder #(
   parameter int XLEN           = 32,
   parameter int LINE_SIZE      = 32,
   parameter int MEM_WORDS      = 1024,
   parameter int ACCESS_LATENCY = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            l1_req_valid,
   input  logic [1:0]      l1_req_type,
   input  logic [XLEN-1:0] l1_req_address,
   input  logic [XLEN-1:0] l1_word_to_store,
   output logic [XLEN-1:0] l1_fetched_word,
   output logic            l1_req_fulfilled,
   output logic            l2_busy
`ifdef L2_ADDR_CHECK_EN
   ,
   output logic            l1_req_error
`endif
);

   localparam logic [1:0] MEM_LOAD  = 2'b00;
   localparam logic [1:0] MEM_STORE = 2'b01;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam int OFF_W = $clog2(XLEN / 8);
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int LAT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

   localparam logic [XLEN-1:0] ERR_WORD = 32'hDEAD_BEEF;

   if (ACCESS_LATENCY < 1 || (MEM_WORDS & (MEM_WORDS - 1)) != 0 ||
       (LINE_SIZE % (XLEN / 8)) != 0) begin : g_bad_cfg
      $error("l2_line_responder: illegal parameter combination");
   end

   logic [1:0]       state_q, state_d;
   logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             is_store_q, is_store_d;
   logic [XLEN-1:0]  store_word_q, store_word_d;
   logic [XLEN-1:0]  fetched_word_q, fetched_word_d;
   logic             fulfilled_q, fulfilled_d;
   logic             bad_q, bad_d;
   logic             error_q, error_d;
   logic             enter_resp;
   logic             req_bad;
   logic             mem_we;

   logic [XLEN-1:0]  mem [MEM_WORDS];

`ifdef L2_ADDR_CHECK_EN
   assign req_bad = (|l1_req_address[OFF_W-1:0]) | (|l1_req_address[XLEN-1:OFF_W+IDX_W]);
   assign l1_req_error = error_q;
`else
   logic unused_addr_bits;
   assign req_bad = 1'b0;
   assign unused_addr_bits = ^{l1_req_address[XLEN-1:OFF_W+IDX_W], l1_req_address[OFF_W-1:0],
                               error_q};
`endif

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case infers a latch.
      state_d        = state_q;
      lat_cnt_d      = lat_cnt_q;
      idx_d          = idx_q;
      is_store_d     = is_store_q;
      store_word_d   = store_word_q;
      fetched_word_d = fetched_word_q;
      bad_d          = bad_q;
      fulfilled_d    = 1'b0;
      error_d        = 1'b0;
      enter_resp     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (l1_req_valid) begin
               idx_d        = l1_req_address[OFF_W +: IDX_W];
               is_store_d   = (l1_req_type == MEM_STORE);
               store_word_d = l1_word_to_store;
               bad_d        = req_bad;
               lat_cnt_d    = LAT_W'(ACCESS_LATENCY - 1);
               if (ACCESS_LATENCY == 1) enter_resp = 1'b1;
               else                     state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            // Leaving at count 1 makes the registered RESP cycle land exactly ACCESS_LATENCY after accept.
            if (lat_cnt_q <= LAT_W'(1)) enter_resp = 1'b1;
            else                        lat_cnt_d  = lat_cnt_q - LAT_W'(1);
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (enter_resp) begin
         state_d     = S_RESP;
         lat_cnt_d   = '0;
         fulfilled_d = 1'b1;
         error_d     = bad_d;
         if (!is_store_d) fetched_word_d = bad_d ? ERR_WORD : mem[idx_d];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         lat_cnt_q      <= '0;
         idx_q          <= '0;
         is_store_q     <= 1'b0;
         store_word_q   <= '0;
         fetched_word_q <= '0;
         fulfilled_q    <= 1'b0;
         bad_q          <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         lat_cnt_q      <= lat_cnt_d;
         idx_q          <= idx_d;
         is_store_q     <= is_store_d;
         store_word_q   <= store_word_d;
         fetched_word_q <= fetched_word_d;
         fulfilled_q    <= fulfilled_d;
         bad_q          <= bad_d;
         error_q        <= error_d;
      end
   end

   // A reset before the RESP edge leaves state_q out of RESP, so an aborted STORE never writes.
   assign mem_we = (state_q == S_RESP) && is_store_q && !bad_q;

   // NOTE: the backing store has no reset; its contents are undefined until written.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx_q] <= store_word_q;
   end

   assign l1_fetched_word  = fetched_word_q;
   assign l1_req_fulfilled = fulfilled_q;
   assign l2_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_l2_line_responder.sv
// Directed bench for l2_line_responder; define L2_ADDR_CHECK_EN to exercise the error path.
module tb_l2_line_responder;

   localparam logic [1:0] MEM_LOAD  = 2'b00;
   localparam logic [1:0] MEM_STORE = 2'b01;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        l1_req_valid = 1'b0;
   logic [1:0]  l1_req_type = MEM_LOAD;
   logic [31:0] l1_req_address = '0;
   logic [31:0] l1_word_to_store = '0;
   logic [31:0] l1_fetched_word;
   logic        l1_req_fulfilled;
   logic        l2_busy;
`ifdef L2_ADDR_CHECK_EN
   logic        l1_req_error;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] fill_word [8];

   always #5 clk = ~clk;

   l2_line_responder #(
      .XLEN(32), .LINE_SIZE(32), .MEM_WORDS(1024), .ACCESS_LATENCY(4)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .l1_req_valid     (l1_req_valid),
      .l1_req_type      (l1_req_type),
      .l1_req_address   (l1_req_address),
      .l1_word_to_store (l1_word_to_store),
      .l1_fetched_word  (l1_fetched_word),
      .l1_req_fulfilled (l1_req_fulfilled),
      .l2_busy          (l2_busy)
`ifdef L2_ADDR_CHECK_EN
      ,
      .l1_req_error     (l1_req_error)
`endif
   );

   // Issue one request from IDLE; returns cycles from accept to fulfilled (0 = timeout).
   task automatic do_req(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] word, output logic err);
      l1_req_valid     = 1'b1;
      l1_req_type      = t;
      l1_req_address   = a;
      l1_word_to_store = d;
      lat  = 0;
      word = '0;
      err  = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (l1_req_fulfilled) begin
            lat  = c;
            word = l1_fetched_word;
`ifdef L2_ADDR_CHECK_EN
            err  = l1_req_error;
`endif
            break;
         end
      end
      l1_req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (l1_req_fulfilled !== 1'b0) begin
         tests_failed++; $display("FAIL reset_fulfilled: got %b, expected 0", l1_req_fulfilled);
      end
      tests_run++;
      if (l2_busy !== 1'b0) begin
         tests_failed++; $display("FAIL reset_busy: got %b, expected 0", l2_busy);
      end
      tests_run++;
      if (l1_fetched_word !== 32'h0) begin
         tests_failed++; $display("FAIL reset_word: got %h, expected 00000000", l1_fetched_word);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      logic exp_ful, exp_busy;
      l1_req_valid     = 1'b1;
      l1_req_type      = MEM_STORE;
      l1_req_address   = 32'h0000_0040;
      l1_word_to_store = 32'hCAFE_F00D;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         exp_ful  = (c == 4);
         exp_busy = (c <= 4);
         tests_run++;
         if (l1_req_fulfilled !== exp_ful) begin
            tests_failed++;
            $display("FAIL latency_fulfilled c=%0d: got %b, expected %b", c, l1_req_fulfilled, exp_ful);
         end
         tests_run++;
         if (l2_busy !== exp_busy) begin
            tests_failed++;
            $display("FAIL latency_busy c=%0d: got %b, expected %b", c, l2_busy, exp_busy);
         end
         if (c == 4) l1_req_valid = 1'b0;
      end
   endtask

   task automatic test_line_fill();
      int lat, beat, last;
      logic [31:0] w;
      logic e;
      for (int i = 0; i < 8; i++) begin
         fill_word[i] = 32'h1000_0000 + 32'h0101 * i;
         do_req(MEM_STORE, 32'h100 + 4 * i, fill_word[i], lat, w, e);
         tests_run++;
         if (lat !== 4) begin
            tests_failed++; $display("FAIL fill_store_lat[%0d]: got %0d, expected 4", i, lat);
         end
      end
      beat = 0;
      last = 0;
      l1_req_valid   = 1'b1;
      l1_req_type    = MEM_LOAD;
      l1_req_address = 32'h11C;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         if (l1_req_fulfilled) begin
            tests_run++;
            if (l1_fetched_word !== fill_word[7 - beat]) begin
               tests_failed++;
               $display("FAIL burst_data[%0d]: got %h, expected %h", beat, l1_fetched_word, fill_word[7 - beat]);
            end
            tests_run++;
            if ((beat == 0 && c != 4) || (beat != 0 && c - last != 5)) begin
               tests_failed++;
               $display("FAIL burst_spacing[%0d]: got cycle %0d after %0d, expected %0d", beat, c, last,
                        (beat == 0) ? 4 : last + 5);
            end
            last = c;
            beat++;
            if (beat == 8) begin
               l1_req_valid = 1'b0;
               break;
            end
            l1_req_address = l1_req_address - 32'd4;
         end
      end
      l1_req_valid = 1'b0;
      tests_run++;
      if (beat !== 8) begin
         tests_failed++; $display("FAIL burst_beats: got %0d, expected 8", beat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store_then_load();
      int lat;
      logic [31:0] w;
      logic e;
      do_req(MEM_STORE, 32'h80, 32'h1234_5678, lat, w, e);
      tests_run++;
      if (lat !== 4 || w !== fill_word[0]) begin
         tests_failed++;
         $display("FAIL store_keeps_word: got lat %0d word %h, expected lat 4 word %h", lat, w, fill_word[0]);
      end
      do_req(MEM_LOAD, 32'h80, 32'h0, lat, w, e);
      tests_run++;
      if (lat !== 4 || w !== 32'h1234_5678) begin
         tests_failed++;
         $display("FAIL load_after_store: got lat %0d word %h, expected lat 4 word 12345678", lat, w);
      end
      // Unknown type behaves as LOAD and must not write its store data.
      do_req(2'b11, 32'h80, 32'hFFFF_FFFF, lat, w, e);
      tests_run++;
      if (w !== 32'h1234_5678) begin
         tests_failed++; $display("FAIL odd_type_load: got %h, expected 12345678", w);
      end
      do_req(MEM_LOAD, 32'h80, 32'h0, lat, w, e);
      tests_run++;
      if (w !== 32'h1234_5678) begin
         tests_failed++; $display("FAIL odd_type_nowrite: got %h, expected 12345678", w);
      end
   endtask

   task automatic test_abort();
      int lat;
      logic [31:0] w;
      logic e;
      do_req(MEM_STORE, 32'h20, 32'h0, lat, w, e);
      l1_req_valid     = 1'b1;
      l1_req_type      = MEM_STORE;
      l1_req_address   = 32'h20;
      l1_word_to_store = 32'hAAAA_AAAA;
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset        = 1'b1;
      l1_req_valid = 1'b0;
      #1;
      tests_run++;
      if (l2_busy !== 1'b0 || l1_req_fulfilled !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_async: got busy %b fulfilled %b, expected 0 0", l2_busy, l1_req_fulfilled);
      end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         tests_run++;
         if (l1_req_fulfilled !== 1'b0) begin
            tests_failed++; $display("FAIL abort_no_pulse c=%0d: got 1, expected 0", c);
         end
      end
      reset = 1'b0;
      @(posedge clk); #1;
      do_req(MEM_LOAD, 32'h20, 32'h0, lat, w, e);
      tests_run++;
      if (lat !== 4 || w !== 32'h0) begin
         tests_failed++;
         $display("FAIL abort_no_write: got lat %0d word %h, expected lat 4 word 00000000", lat, w);
      end
   endtask

   task automatic test_valid_drop();
      l1_req_valid   = 1'b1;
      l1_req_type    = MEM_LOAD;
      l1_req_address = 32'h80;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c == 1) l1_req_valid = 1'b0;
         tests_run++;
         if (l1_req_fulfilled !== (c == 4)) begin
            tests_failed++;
            $display("FAIL drop_fulfilled c=%0d: got %b, expected %b", c, l1_req_fulfilled, (c == 4));
         end
         if (c == 4) begin
            tests_run++;
            if (l1_fetched_word !== 32'h1234_5678) begin
               tests_failed++; $display("FAIL drop_data: got %h, expected 12345678", l1_fetched_word);
            end
         end
         if (c >= 5) begin
            tests_run++;
            if (l2_busy !== 1'b0) begin
               tests_failed++; $display("FAIL drop_no_second c=%0d: got busy 1, expected 0", c);
            end
         end
      end
   endtask

`ifdef L2_ADDR_CHECK_EN
   task automatic test_addr_check();
      int lat;
      logic [31:0] w;
      logic e;
      do_req(MEM_LOAD, 32'h0000_1000, 32'h0, lat, w, e);
      tests_run++;
      if (e !== 1'b1 || w !== 32'hDEAD_BEEF) begin
         tests_failed++; $display("FAIL err_load_range: got err %b word %h, expected 1 deadbeef", e, w);
      end
      do_req(MEM_STORE, 32'h0000_0042, 32'h5555_5555, lat, w, e);
      tests_run++;
      if (e !== 1'b1) begin
         tests_failed++; $display("FAIL err_store_misaligned: got err %b, expected 1", e);
      end
      do_req(MEM_LOAD, 32'h0000_0040, 32'h0, lat, w, e);
      tests_run++;
      if (e !== 1'b0 || w !== 32'hCAFE_F00D) begin
         tests_failed++; $display("FAIL err_store_nowrite: got err %b word %h, expected 0 cafef00d", e, w);
      end
   endtask
`else
   task automatic test_alias();
      int lat;
      logic [31:0] w;
      logic e;
      do_req(MEM_LOAD, 32'h0000_1040, 32'h0, lat, w, e);
      tests_run++;
      if (w !== 32'hCAFE_F00D) begin
         tests_failed++; $display("FAIL alias_upper: got %h, expected cafef00d", w);
      end
      do_req(MEM_LOAD, 32'h0000_0082, 32'h0, lat, w, e);
      tests_run++;
      if (w !== 32'h1234_5678) begin
         tests_failed++; $display("FAIL alias_misaligned: got %h, expected 12345678", w);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_line_fill();
      test_store_then_load();
      test_abort();
      test_valid_drop();
`ifdef L2_ADDR_CHECK_EN
      test_addr_check();
`else
      test_alias();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
